// File: rtl/smss_pkg.sv
// Shared definitions for the SMSS power-map engine.
//   SMSS_M     : default field degree (element / exponent width)
//   SMSS_POLY  : default irreducible polynomial, bit i = coeff of z^i
//   SMSS_LANES : default number of parallel S-box lanes
//   SMSS_ONE   : field element 1 in polynomial basis
//   state_t    : engine FSM states
package smss_pkg;

  localparam int unsigned SMSS_M     = 6;
  localparam logic [6:0]  SMSS_POLY  = 7'h43;
  localparam int unsigned SMSS_LANES = 4;

  localparam logic [SMSS_M-1:0] SMSS_ONE = SMSS_M'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/smss_power_iter_if.sv
// Valid/ready transaction bus of the power-map engine.
//   in_valid/in_ready  : input handshake, in_x (LANES*M operands), in_exp (M)
//   out_valid/out_ready: output handshake, out_y (LANES*M results)
// master = producer/consumer side (bench or datapath), slave = engine.
interface smss_power_iter_if
  import smss_pkg::*;
#(
  parameter int unsigned M     = SMSS_M,
  parameter int unsigned LANES = SMSS_LANES
);

  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*M-1:0]   in_x;
  logic [M-1:0]         in_exp;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*M-1:0]   out_y;

  modport master (
    output in_valid, in_x, in_exp, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, in_exp, out_ready,
    output in_ready, out_valid, out_y
  );

endinterface

// File: rtl/gf2m_mul.sv
// Combinational GF(2^M) multiplier.
//   a, b : M-bit operands in polynomial basis
//   p    : a*b mod POLY
// Carry-less product followed by MSB-first reduction of the 2M-1 bit result.
module gf2m_mul
  import smss_pkg::*;
#(
  parameter int unsigned M    = SMSS_M,
  parameter logic [M:0]  POLY = (M+1)'(SMSS_POLY)
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [2*M-2:0] prod;
  logic [2*M-2:0] red;

  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) prod = prod ^ ((2*M-1)'(a) << i);
    end
    red = prod;
    for (int unsigned i = 2*M-2; i >= M; i--) begin
      if (red[i]) red = red ^ ((2*M-1)'(POLY) << (i - M));
    end
    p = red[M-1:0];
  end

endmodule

// File: rtl/smss_power_iter.sv
// Iterative constant-time power-map S-box engine: y = x^e in GF(2^M).
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   clr      : synchronous abort back to IDLE, result discarded
//   io       : slave side of the valid/ready transaction bus
//   busy     : high while a transaction is in RUN or DONE
// LANES lanes share one exponent; MSB-first square-and-multiply always
// spends exactly M RUN cycles.
module smss_power_iter
  import smss_pkg::*;
#(
  parameter int unsigned M     = SMSS_M,
  parameter logic [M:0]  POLY  = (M+1)'(SMSS_POLY),
  parameter int unsigned LANES = SMSS_LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  smss_power_iter_if.slave   io,
  output logic               busy
);

  localparam int unsigned   CW  = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned   W   = LANES * M;
  localparam logic [M-1:0]  ONE = M'(SMSS_ONE);

  state_t          state_q, state_d;
  logic [W-1:0]    opx_q, opx_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    out_y_q, out_y_d;
  logic [M-1:0]    exp_q, exp_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    sq;
  logic [W-1:0]    sqx;
  logic [W-1:0]    acc_next;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gf2m_mul #(.M(M), .POLY(POLY)) u_sq (
      .a (acc_q[k*M +: M]),
      .b (acc_q[k*M +: M]),
      .p (sq[k*M +: M])
    );
    gf2m_mul #(.M(M), .POLY(POLY)) u_mx (
      .a (sq[k*M +: M]),
      .b (opx_q[k*M +: M]),
      .p (sqx[k*M +: M])
    );
  end

  assign acc_next = exp_q[cnt_q] ? sqx : sq;

  always_comb begin
    state_d = state_q;
    opx_d   = opx_q;
    acc_d   = acc_q;
    out_y_d = out_y_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            opx_d   = io.in_x;
            exp_d   = io.in_exp;
            acc_d   = {LANES{ONE}};
            cnt_d   = CW'(M - 1);
            state_d = RUN;
          end
        end
        RUN: begin
          acc_d = acc_next;
          if (cnt_q == '0) begin
            out_y_d = acc_next;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opx_q   <= '0;
      acc_q   <= '0;
      out_y_q <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opx_q   <= opx_d;
      acc_q   <= acc_d;
      out_y_q <= out_y_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_y     = out_y_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_smss_power_iter.sv
module tb_smss_power_iter;

  localparam int unsigned M     = 6;
  localparam int unsigned LANES = 4;
  localparam int unsigned W     = LANES * M;
  localparam logic [M:0]  POLY  = 7'h43;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  smss_power_iter_if #(.M(M), .LANES(LANES)) bus ();

  smss_power_iter #(.M(M), .POLY(POLY), .LANES(LANES)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .io   (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference: LSB-first shift-and-add multiply, power by repeated multiply.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0]   aa;
    logic [M-1:0] r;
    aa = {1'b0, a};
    r  = '0;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ aa[M-1:0];
      aa = aa << 1;
      if (aa[M]) aa = aa ^ POLY;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] ref_pow(input logic [M-1:0] x, input logic [M-1:0] e);
    logic [M-1:0] r;
    r = M'(1);
    for (int i = 0; i < int'(e); i++) r = ref_mul(r, x);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_vec(input logic [W-1:0] x, input logic [M-1:0] e);
    logic [W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*M +: M] = ref_pow(x[k*M +: M], e);
    return v;
  endfunction

  task automatic do_txn(input logic [W-1:0] x, input logic [M-1:0] e,
                        output logic [W-1:0] got, output bit timeout);
    int n;
    exp_q.push_back(ref_vec(x, e));
    timeout = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) timeout = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_exp   = e;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = W'($urandom);
    bus.in_exp   = M'($urandom);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.out_valid) timeout = 1'b1;
    got = bus.out_y;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_y !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_y=%h, want 1 0 0 000000",
               bus.in_ready, bus.out_valid, busy, bus.out_y);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity_latency();
    logic [W-1:0] x, expv;
    int n;
    bit seen_busy;
    x = {6'h21, 6'h00, 6'h01, 6'h02};
    exp_q.push_back(ref_vec(x, 6'd1));
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_exp   = 6'd1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = '1;
    seen_busy = busy;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    checks++;
    if (n != 6 || !bus.out_valid) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges (valid=%b), want 6", n, bus.out_valid);
    end
    checks++;
    if (seen_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_run: busy=%b, want 1", seen_busy);
    end
    expv = exp_q.pop_front();
    checks++;
    if (bus.out_y !== expv) begin
      errors++;
      $display("FAIL identity: got %h want %h", bus.out_y, expv);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_known_powers();
    logic [M-1:0] es[3] = '{6'd6, 6'd7, 6'd62};
    logic [M-1:0] ys[3] = '{6'h03, 6'h06, 6'h21};
    logic [W-1:0] got, expv;
    bit to;
    for (int i = 0; i < 3; i++) begin
      do_txn({6'h05, 6'h3F, 6'h00, 6'h02}, es[i], got, to);
      expv = exp_q.pop_front();
      checks++;
      if (to || got !== expv || got[M-1:0] !== ys[i]) begin
        errors++;
        $display("FAIL known_pow e=%0d: got %h want %h lane0 %h timeout=%0d",
                 es[i], got, expv, ys[i], to);
      end
    end
  endtask

  task automatic test_inverse();
    logic [W-1:0] x, got, expv;
    logic [M-1:0] xl;
    bit to;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < LANES; k++) x[k*M +: M] = M'(4*i + k);
      do_txn(x, 6'd62, got, to);
      expv = exp_q.pop_front();
      checks++;
      if (to || got !== expv) begin
        errors++;
        $display("FAIL inverse_sb: x=%h got %h want %h timeout=%0d", x, got, expv, to);
      end
      for (int k = 0; k < LANES; k++) begin
        xl = x[k*M +: M];
        if (xl != '0) begin
          checks++;
          if (ref_mul(xl, got[k*M +: M]) !== M'(1)) begin
            errors++;
            $display("FAIL inverse_prod: x=%h inv=%h product %h want 01",
                     xl, got[k*M +: M], ref_mul(xl, got[k*M +: M]));
          end
        end
      end
    end
  endtask

  task automatic test_boundary_exps();
    logic [W-1:0] x, got, expv;
    bit to;
    x = {6'h2A, 6'h15, 6'h3F, 6'h00};
    do_txn(x, 6'd0, got, to);
    expv = exp_q.pop_front();
    checks++;
    if (to || got !== expv || got !== {4{6'h01}}) begin
      errors++;
      $display("FAIL exp_zero: got %h want %h timeout=%0d", got, expv, to);
    end
    do_txn(x, 6'd63, got, to);
    expv = exp_q.pop_front();
    checks++;
    if (to || got !== expv || got !== {6'h01, 6'h01, 6'h01, 6'h00}) begin
      errors++;
      $display("FAIL exp_max: got %h want %h timeout=%0d", got, expv, to);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, held, expv;
    int n;
    x = {6'h11, 6'h22, 6'h33, 6'h04};
    exp_q.push_back(ref_vec(x, 6'd23));
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_exp   = 6'd23;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    held = bus.out_y;
    expv = exp_q.pop_front();
    checks++;
    if (!bus.out_valid || held !== expv) begin
      errors++;
      $display("FAIL bp_result: got %h want %h valid=%b", held, expv, bus.out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = W'($urandom);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_y !== held || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b y=%h in_ready=%b, want 1 %h 0",
                 c, bus.out_valid, bus.out_y, bus.in_ready, held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_y !== held) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b valid=%b y=%h, want 1 0 %h",
               bus.in_ready, bus.out_valid, bus.out_y, held);
    end
  endtask

  task automatic test_clr();
    logic [W-1:0] got, expv;
    bit to, saw_valid;
    bus.in_valid = 1'b1;
    bus.in_x     = {4{6'h07}};
    bus.in_exp   = 6'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_abort: saw_valid=%b in_ready=%b busy=%b, want 0 1 0",
               saw_valid, bus.in_ready, busy);
    end
    clr = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: in_ready=%b busy=%b, want 1 0", bus.in_ready, busy);
    end
    do_txn({6'h02, 6'h02, 6'h02, 6'h02}, 6'd6, got, to);
    expv = exp_q.pop_front();
    checks++;
    if (to || got !== expv || got[M-1:0] !== 6'h03) begin
      errors++;
      $display("FAIL clr_next: got %h want %h timeout=%0d", got, expv, to);
    end
  endtask

  task automatic test_rst_mid_run();
    bus.in_valid = 1'b1;
    bus.in_x     = {4{6'h09}};
    bus.in_exp   = 6'd13;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_y !== '0) begin
      errors++;
      $display("FAIL rst_async: in_ready=%b out_valid=%b busy=%b out_y=%h, want 1 0 0 000000",
               bus.in_ready, bus.out_valid, busy, bus.out_y);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exhaustive_23();
    logic [W-1:0] x, got, expv;
    bit to;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < LANES; k++) x[k*M +: M] = M'(i + 16*k);
      do_txn(x, 6'd23, got, to);
      expv = exp_q.pop_front();
      checks++;
      if (to || got !== expv) begin
        errors++;
        $display("FAIL pow23: x=%h got %h want %h timeout=%0d", x, got, expv, to);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_identity_latency();
    test_known_powers();
    test_inverse();
    test_boundary_exps();
    test_backpressure();
    test_clr();
    test_rst_mid_run();
    test_exhaustive_23();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smss_power_iter.md
Name: smss_power_iter

Overview:
- Iterative, constant-time power-map S-box engine: y = x^e in GF(2^M), with exponent e supplied at run time per transaction.
- Generalises the fixed-exponent combinational SMSS32 power maps (x^23 etc.): parametrised field, LANES parallel S-boxes sharing one exponent, valid/ready handshake, MSB-first square-and-multiply FSM.
- Sits between the SMSS32 test harnesses / cipher datapaths and the field arithmetic; used for exploring exponents without regenerating RTL.

Parameters:
- M, 6, field degree; element and exponent width in bits.
- POLY, 7'h43, irreducible field polynomial, bit i = coefficient of z^i (default z^6+z+1); must have bit M set.
- LANES, 4, number of parallel S-boxes per transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous abort; returns FSM to IDLE.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  engine can accept (high only in IDLE).
- in_x  in  LANES*M  lane k operand at bits [k*M +: M].
- in_exp  in  M  exponent e, shared by all lanes.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  LANES*M  lane k result at bits [k*M +: M].
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, out_y=0, internal accumulators, operands, exponent and counter = 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On edge with in_valid=1: latch in_x into operand regs, in_exp into exponent reg, set every lane accumulator to 1 (constant 1 in polynomial basis), cnt=M-1, go RUN.
- RUN: each edge, for every lane: acc <= (e[cnt]=1) ? acc^2*x : acc^2. Square and multiply are both mod POLY, within one cycle. cnt decrements. Leave RUN on the edge that processes cnt=0.
- Exactly M RUN cycles regardless of exponent value or operand. No leading-zero skipping; constant time is mandatory.
- DONE: out_valid=1, out_y=accumulators (registered, stable while out_valid=1). On edge with out_ready=1, go IDLE. out_y keeps its last value after the handshake.
- Latency: handshake accept at edge T, out_valid high from edge T+M. Throughput: at most one transaction per M+2 cycles. No accept in the cycle of the output handshake, because in_ready=0 in DONE.
- Arithmetic: carry-less multiply of two M-bit values, then reduce the 2M-1 bit product mod POLY. Squaring may reuse the multiplier or use a dedicated linear map; results must be identical.
- Boundary values:
  - e=0 gives 1 for all lanes, including x=0 (0^0 := 1).
  - x=0 with e!=0 gives 0.
  - e=2^M-1 gives 1 for x!=0 and 0 for x=0.
  - e=2^M-2 gives the field inverse, with 0 mapping to 0.
- clr=1 in any state: next edge goes IDLE, out_valid=0, the in-flight result is discarded. clr has priority over in_valid and out_ready. If clr and in_valid are both high in IDLE, nothing is accepted.
- rst asserted mid-RUN or in DONE: immediate return to reset values.
- in_x and in_exp are ignored outside the accept edge.

Decomposition:
- Shared package smss_pkg: default M, POLY and LANES constants; a function or constant for the field value 1; FSM state enum (IDLE, RUN, DONE).
- One sub-module, gf2m_mul (parameters M, POLY): combinational a*b mod POLY.
- Top instantiates 2*LANES gf2m_mul (square and multiply per lane) plus the FSM and counter.

Test Plan:
- Lanes {0x02,0x01,0x00,0x21}, e=1 -> out_y {0x02,0x01,0x00,0x21}, with out_valid rising exactly 6 cycles after the accept edge.
- Lane x=0x02, e=6 -> 0x03; e=7 -> 0x06; e=62 -> 0x21. Also check that the e=62 result times x equals 1 for all 63 nonzero x.
- e=0 with lanes {0x00,0x3F,0x15,0x2A} -> all 0x01; e=63 with the same lanes -> {0x00,0x01,0x01,0x01}.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_y stable, in_ready=0; then a single out_ready pulse -> IDLE next cycle and in_ready=1.
- clr pulsed in the 3rd RUN cycle -> out_valid never asserts, next transaction (x=0x02, e=6) returns 0x03. rst pulsed mid-RUN -> all outputs return to reset values asynchronously.
- Exhaustive e=23, all 64 x on lane 0 -> matches the SMSS32_23_nn_2_5 output for the same x, with POLY set to the field polynomial of the SMSS32 family.
